// File: rtl/ecall_stat_unit.sv
// ecall service decode (halt/step, display channels) and PC enable.
// Ports: clk/rst, ecall/svc/arg, jump/branch_taken, go, clr, led_sel -> pc_en/halted/led_out/counters.
module ecall_stat_unit #(
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int HALT_CODE  = 10,
  parameter int PRINT_BASE = 1,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ecall,
  input  logic [DATA_W-1:0] svc,
  input  logic [DATA_W-1:0] arg,
  input  logic              jump,
  input  logic              branch_taken,
  input  logic              go,
  input  logic              clr,
  input  logic [SEL_W-1:0]  led_sel,
  output logic              pc_en,
  output logic              halted,
  output logic [DATA_W-1:0] led_out,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  jump_cnt,
  output logic [CNT_W-1:0]  branch_cnt
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] HALT = 2'd1;
  localparam logic [1:0] STEP = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nx;

  logic g1;
  logic g2;
  logic g3;
  logic go_rise;

  logic halt_req;
  logic [NUM_CH-1:0] wr;
  logic [DATA_W-1:0] ch [NUM_CH];

  // Resume button: two-flop synchroniser plus an edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g1 <= 1'b0;
      g2 <= 1'b0;
      g3 <= 1'b0;
    end else begin
      g1 <= go;
      g2 <= g1;
      g3 <= g2;
    end
  end

  assign go_rise  = g2 & ~g3;
  assign halt_req = ecall & (svc == DATA_W'(HALT_CODE));

  always_comb begin
    state_nx = state;
    pc_en    = 1'b1;
    case (state)
      RUN: begin
        if (halt_req) begin
          pc_en    = 1'b0;
          state_nx = HALT;
        end
      end
      HALT: begin
        pc_en = 1'b0;
        if (go_rise) state_nx = STEP;
      end
      // The PC advances past the halting ecall here,
      // so halt_req is deliberately not looked at.
      STEP: begin
        pc_en    = 1'b1;
        state_nx = RUN;
      end
      default: begin
        pc_en    = 1'b1;
        state_nx = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nx;
  end

  assign halted = (state == HALT);

  // Display writes only from RUN; one compare per channel.
  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = (state == RUN) & ecall &
              (svc == DATA_W'(PRINT_BASE + i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) ch[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr[i]) ch[i] <= arg;
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    led_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (led_sel == SEL_W'(i)) led_out = ch[i];
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt  <= '0;
      jump_cnt   <= '0;
      branch_cnt <= '0;
    end else if (clr) begin
      cycle_cnt  <= '0;
      jump_cnt   <= '0;
      branch_cnt <= '0;
    end else if (pc_en) begin
      cycle_cnt <= sat_inc(cycle_cnt);
      if (jump)         jump_cnt   <= sat_inc(jump_cnt);
      if (branch_taken) branch_cnt <= sat_inc(branch_cnt);
    end
  end

endmodule

// File: tb/tb_ecall_stat_unit.sv
// Bench for ecall_stat_unit: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_ecall_stat_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ecall = 1'b0;
  logic [31:0] svc = '0;
  logic [31:0] arg = '0;
  logic        jump = 1'b0;
  logic        branch_taken = 1'b0;
  logic        go = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  led_sel = '0;

  logic        pc_en;
  logic        halted;
  logic [31:0] led_out;
  logic [31:0] cycle_cnt;
  logic [31:0] jump_cnt;
  logic [31:0] branch_cnt;

  logic        s_pc_en;
  logic        s_halted;
  logic [31:0] s_led;
  logic [3:0]  s_cyc;
  logic [3:0]  s_jmp;
  logic [3:0]  s_br;

  ecall_stat_unit dut (
    .clk(clk), .rst(rst), .ecall(ecall), .svc(svc), .arg(arg),
    .jump(jump), .branch_taken(branch_taken), .go(go), .clr(clr),
    .led_sel(led_sel), .pc_en(pc_en), .halted(halted),
    .led_out(led_out), .cycle_cnt(cycle_cnt), .jump_cnt(jump_cnt),
    .branch_cnt(branch_cnt)
  );

  ecall_stat_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .ecall(ecall), .svc(svc), .arg(arg),
    .jump(jump), .branch_taken(branch_taken), .go(go), .clr(clr),
    .led_sel(led_sel), .pc_en(s_pc_en), .halted(s_halted),
    .led_out(s_led), .cycle_cnt(s_cyc), .jump_cnt(s_jmp),
    .branch_cnt(s_br)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: 0 running, 1 halted, 2 single-step
  int          m_mode;
  logic [31:0] m_ch [4];
  longint      m_cyc, m_jmp, m_br;
  bit          gh [3];

  function automatic bit m_pc_en();
    if (m_mode == 1) return 1'b0;
    if (m_mode == 2) return 1'b1;
    return !(ecall && svc == 32'd10);
  endfunction

  function automatic longint sat(longint v, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic m_reset();
    m_mode = 0;
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
    m_cyc = 0; m_jmp = 0; m_br = 0;
    for (int i = 0; i < 3; i++) gh[i] = 1'b0;
  endtask

  task automatic tick();
    bit pe, rise;
    pe   = m_pc_en();
    rise = gh[1] && !gh[2];
    @(posedge clk);
    if (clr) begin
      m_cyc = 0; m_jmp = 0; m_br = 0;
    end else if (pe) begin
      m_cyc++;
      if (jump) m_jmp++;
      if (branch_taken) m_br++;
    end
    if (m_mode == 0 && ecall && svc >= 1 && svc < 5)
      m_ch[svc - 1] = arg;
    if (m_mode == 0) begin
      if (ecall && svc == 32'd10) m_mode = 1;
    end else if (m_mode == 1) begin
      if (rise) m_mode = 2;
    end else begin
      m_mode = 0;
    end
    gh[2] = gh[1]; gh[1] = gh[0]; gh[0] = go;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m_reset();
    #3;
    checks++;
    if (pc_en !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl pc_en=%b halted=%b want 1 0", pc_en, halted);
    end
    checks++;
    if (cycle_cnt !== 0 || led_out !== 0) begin
      errors++;
      $display("FAIL reset_val cyc=%0d led=%h want 0 0", cycle_cnt, led_out);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) tick();
    checks++;
    if (cycle_cnt !== 32'd5 || jump_cnt !== 0 || branch_cnt !== 0) begin
      errors++;
      $display("FAIL idle5 cyc=%0d jmp=%0d br=%0d want 5 0 0",
               cycle_cnt, jump_cnt, branch_cnt);
    end
    checks++;
    if (pc_en !== 1'b1 || led_out !== 0) begin
      errors++;
      $display("FAIL idle5_ctl pc_en=%b led=%h want 1 0", pc_en, led_out);
    end
  endtask

  task automatic test_print();
    ecall = 1'b1; svc = 32'd2; arg = 32'hDEADBEEF; led_sel = 2'd1;
    #1;
    checks++;
    if (pc_en !== 1'b1) begin
      errors++;
      $display("FAIL print_pc_en got %b want 1", pc_en);
    end
    tick();
    ecall = 1'b0;
    #1;
    checks++;
    if (led_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL print_ch1 got %h want deadbeef", led_out);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) continue;
      led_sel = 2'(i);
      #1;
      checks++;
      if (led_out !== 32'h0) begin
        errors++;
        $display("FAIL print_other ch%0d got %h want 0", i, led_out);
      end
    end
  endtask

  task automatic test_halt();
    longint c0;
    int steps;
    bit was_step;
    ecall = 1'b1; svc = 32'd10;
    #1;
    checks++;
    if (pc_en !== 1'b0) begin
      errors++;
      $display("FAIL halt_pc_en got %b want 0", pc_en);
    end
    c0 = m_cyc;
    tick();
    checks++;
    if (halted !== 1'b1 || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL halt_state halted=%b pc_en=%b want 1 0", halted, pc_en);
    end
    repeat (3) tick();
    checks++;
    if (cycle_cnt !== 32'(c0)) begin
      errors++;
      $display("FAIL halt_frozen cyc=%0d want %0d", cycle_cnt, c0);
    end
    go = 1'b1;
    steps = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (pc_en !== m_pc_en()) begin
        errors++;
        $display("FAIL step_pc_en cyc%0d got %b want %b", i, pc_en, m_pc_en());
      end
      was_step = pc_en && ecall;
      if (was_step) steps++;
      tick();
      if (was_step) ecall = 1'b0;
    end
    checks++;
    if (steps !== 1) begin
      errors++;
      $display("FAIL step_count got %0d want 1", steps);
    end
    checks++;
    if (halted !== 1'b0 || pc_en !== 1'b1) begin
      errors++;
      $display("FAIL step_resume halted=%b pc_en=%b want 0 1", halted, pc_en);
    end
    checks++;
    if (cycle_cnt !== 32'(sat(m_cyc, 32))) begin
      errors++;
      $display("FAIL step_cnt got %0d want %0d", cycle_cnt, m_cyc);
    end
    go = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_counters();
    clr = 1'b1; tick(); clr = 1'b0;
    jump = 1'b1; tick();
    branch_taken = 1'b1; tick();
    checks++;
    if (jump_cnt !== 32'd2 || branch_cnt !== 32'd1 || cycle_cnt !== 32'd2) begin
      errors++;
      $display("FAIL cnt_pre jmp=%0d br=%0d cyc=%0d want 2 1 2",
               jump_cnt, branch_cnt, cycle_cnt);
    end
    clr = 1'b1; tick();
    clr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    checks++;
    if (jump_cnt !== 0 || branch_cnt !== 0 || cycle_cnt !== 0) begin
      errors++;
      $display("FAIL cnt_clr jmp=%0d br=%0d cyc=%0d want 0 0 0",
               jump_cnt, branch_cnt, cycle_cnt);
    end
    repeat (20) tick();
    checks++;
    if (s_cyc !== 4'd15 || cycle_cnt !== 32'd20) begin
      errors++;
      $display("FAIL cnt_sat small=%0d big=%0d want 15 20", s_cyc, cycle_cnt);
    end
  endtask

  task automatic test_reset_halt();
    ecall = 1'b1; svc = 32'd1; arg = 32'h12; tick();
    svc = 32'd10; tick();
    led_sel = 2'd0;
    #1;
    checks++;
    if (halted !== 1'b1 || led_out !== 32'h12) begin
      errors++;
      $display("FAIL rsth_pre halted=%b led=%h want 1 12", halted, led_out);
    end
    ecall = 1'b0;
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    checks++;
    if (halted !== 1'b0 || pc_en !== 1'b1) begin
      errors++;
      $display("FAIL rsth_ctl halted=%b pc_en=%b want 0 1", halted, pc_en);
    end
    checks++;
    if (led_out !== 0 || cycle_cnt !== 0 || jump_cnt !== 0 ||
        branch_cnt !== 0 || s_cyc !== 0) begin
      errors++;
      $display("FAIL rsth_val led=%h cyc=%0d jmp=%0d br=%0d want 0",
               led_out, cycle_cnt, jump_cnt, branch_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (cycle_cnt !== 32'd1 || pc_en !== 1'b1) begin
      errors++;
      $display("FAIL rsth_run cyc=%0d pc_en=%b want 1 1", cycle_cnt, pc_en);
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 400; n++) begin
      ecall = ($urandom % 3) == 0;
      r = $urandom % 8;
      if (r < 5)       svc = 32'(r);
      else if (r == 5) svc = 32'd10;
      else if (r == 6) svc = $urandom;
      else             svc = 32'd5;
      arg = $urandom;
      jump = $urandom % 2;
      branch_taken = $urandom % 2;
      clr = ($urandom % 50) == 0;
      if (($urandom % 5) == 0) go = ~go;
      led_sel = 2'($urandom);
      #1;
      checks++;
      if (pc_en !== m_pc_en() || halted !== (m_mode == 1)) begin
        errors++;
        $display("FAIL rnd_ctl n=%0d pc_en=%b halted=%b want %b %b",
                 n, pc_en, halted, m_pc_en(), m_mode == 1);
      end
      checks++;
      if (led_out !== m_ch[led_sel]) begin
        errors++;
        $display("FAIL rnd_led n=%0d got %h want %h", n, led_out, m_ch[led_sel]);
      end
      checks++;
      if (cycle_cnt !== 32'(sat(m_cyc, 32)) ||
          jump_cnt !== 32'(sat(m_jmp, 32)) ||
          branch_cnt !== 32'(sat(m_br, 32))) begin
        errors++;
        $display("FAIL rnd_cnt n=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 n, cycle_cnt, jump_cnt, branch_cnt, m_cyc, m_jmp, m_br);
      end
      checks++;
      if (s_cyc !== 4'(sat(m_cyc, 4)) || s_jmp !== 4'(sat(m_jmp, 4)) ||
          s_br !== 4'(sat(m_br, 4))) begin
        errors++;
        $display("FAIL rnd_sat n=%0d got %0d/%0d/%0d", n, s_cyc, s_jmp, s_br);
      end
      tick();
    end
    ecall = 1'b0; clr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    test_reset();
    test_print();
    test_halt();
    test_counters();
    test_reset_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecall_stat_unit.md
Name: ecall_stat_unit

Overview:
- Environment-call service and performance-statistics unit for the single-cycle RISC-V core.
- Sits beside the PC register. Decodes ecall service codes:
  - halt with a debounced single-step resume;
  - writes to NUM_CH display channels.
- Drives the PC clock-enable.
- Keeps saturating cycle, jump and taken-branch counters for the board display.

Parameters:
- DATA_W, 32, width of service code, argument and display channels.
- NUM_CH, 4, number of display channels (>=1).
- CNT_W, 32, width of each statistics counter.
- HALT_CODE, 10, service code (a7) that halts the core.
- PRINT_BASE, 1, first display service code; codes PRINT_BASE..PRINT_BASE+NUM_CH-1 select channel 0..NUM_CH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ecall  in  1  current instruction is ecall (decoder output).
- svc  in  DATA_W  service code (register a7 read value).
- arg  in  DATA_W  service argument (register a0 read value).
- jump  in  1  current instruction is JAL or JALR.
- branch_taken  in  1  conditional branch taken this cycle.
- go  in  1  asynchronous resume button.
- clr  in  1  synchronous clear of all statistics counters.
- led_sel  in  max(1,$clog2(NUM_CH))  display channel select.
- pc_en  out  1  PC register clock-enable.
- halted  out  1  high while in HALT state.
- led_out  out  DATA_W  selected display channel.
- cycle_cnt  out  CNT_W  executed-cycle counter.
- jump_cnt  out  CNT_W  executed-jump counter.
- branch_cnt  out  CNT_W  taken-branch counter.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN;
  - all channels, counters and go synchroniser flops = 0;
  - halted=0.
- go synchroniser: two flops (g1, g2), then a delay flop g3. go_rise = g2 & ~g3. A go rise is seen on the 2nd edge after go rises.
- State machine RUN / HALT / STEP. halt_req = ecall & (svc==HALT_CODE).
  - RUN: pc_en = ~halt_req (combinational). If halt_req, next state = HALT; PC holds on the ecall.
  - HALT: pc_en=0, halted=1. If go_rise, next state = STEP; otherwise stay.
  - STEP: pc_en=1 for exactly one cycle. halt_req is ignored, so the PC leaves the halting ecall. Next state = RUN.
  - go held high produces one go_rise only, so there is exactly one resume per press.
- Display write:
  - In RUN with ecall & PRINT_BASE <= svc < PRINT_BASE+NUM_CH: channel[svc-PRINT_BASE] <= arg at the next edge.
  - In HALT or STEP: no writes.
  - Unknown service codes: ignored, pc_en stays 1.
- Comparisons are unsigned on the full DATA_W.
- led_out = channel[led_sel], combinational. led_sel >= NUM_CH gives 0.
- Counters: each counter increments at the edge only if pc_en=1 in that cycle.
  - cycle_cnt: every such cycle.
  - jump_cnt: when jump=1.
  - branch_cnt: when branch_taken=1.
- Counter boundaries:
  - Each counter saturates at 2^CNT_W-1; no wrap.
  - clr=1 forces all counters to 0 and takes priority over a simultaneous increment.
  - The halting ecall cycle (pc_en=0) is not counted.
  - The STEP cycle is counted.
- Reset mid-HALT returns to RUN with pc_en=1 immediately after release.

Test Plan:
- Reset, then 5 cycles with no ecall/jump/branch -> pc_en=1, cycle_cnt=5, jump_cnt=0, branch_cnt=0, led_out=0.
- ecall, svc=2, arg=0xDEADBEEF, led_sel=1 -> led_out=0xDEADBEEF after the next edge; channels 0, 2 and 3 stay 0; pc_en=1 throughout.
- ecall, svc=10 held -> pc_en=0 the same cycle, halted=1 after the edge, cycle_cnt frozen.
  - go raised and held 20 cycles -> exactly one STEP cycle with pc_en=1; no re-halt; returns to RUN.
- jump=1 for 3 cycles and branch_taken=1 for 2 cycles, with clr=1 coinciding with the last branch -> all counters read 0 after that edge.
- CNT_W=4 build, 20 RUN cycles -> cycle_cnt stays 15.
- rst pulsed low while halted, with channel 0 = 0x12 -> halted=0, pc_en=1, channel 0 = 0, counters 0, asynchronously before the next clock edge.
